// File: rtl/mixer_pkg.sv
// Shared constants for the mixing plant: tank limits, valve rates, timer period
// and fault flag indices, used by the plant model and its controller.
package mixer_pkg;

   localparam int unsigned LEVEL_W = 8;
   localparam int unsigned SUM_W   = 10;

   localparam int unsigned DEF_MAX_LEVEL    = 200;
   localparam int unsigned DEF_P1_THRESH    = 100;
   localparam int unsigned DEF_P2_THRESH    = 20;
   localparam int unsigned DEF_TIMER_CYCLES = 50;

   localparam int unsigned RATE_V1 = 2;
   localparam int unsigned RATE_V2 = 1;
   localparam int unsigned RATE_V3 = 3;

   localparam int unsigned FAULT_W   = 2;
   localparam int unsigned FAULT_OVF = 0;
   localparam int unsigned FAULT_DRY = 1;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_e;

   // Clamp a signed net-flow result into the 0..max tank range.
   function automatic logic [LEVEL_W-1:0] sat_level(input logic signed [SUM_W-1:0] sum,
                                                   input logic signed [SUM_W-1:0] max);
      logic [LEVEL_W-1:0] res;
      if (sum[SUM_W-1])
         res = '0;
      else if (sum > max)
         res = LEVEL_W'(max);
      else
         res = LEVEL_W'(sum);
      return res;
   endfunction

endpackage

// File: rtl/mixer_timer.sv
// Run timer: counts edges with T high and emits a registered one-cycle TOK
// every TIMER_CYCLES such edges; dropping T returns to IDLE with a zero count.
module mixer_timer
   import mixer_pkg::*;
#(
   parameter int unsigned TIMER_CYCLES = DEF_TIMER_CYCLES
) (
   input  logic Clk,
   input  logic Reset,
   input  logic T,
   output logic TOK
);

   localparam int unsigned CNT_W = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMER_CYCLES - 1);

   tmr_state_e       state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic             tok_n;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= TMR_IDLE;
         count <= '0;
         TOK   <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         TOK   <= tok_n;
      end
   end

   // The IDLE->RUN edge already counts as the first edge with T high.
   always_comb begin
      state_n = state;
      count_n = count;
      tok_n   = 1'b0;
      case (state)
         TMR_IDLE: begin
            count_n = '0;
            if (T) begin
               state_n = TMR_RUN;
               if (TERM == '0)
                  tok_n = 1'b1;
               else
                  count_n = CNT_W'(1);
            end
         end
         TMR_RUN: begin
            if (!T) begin
               state_n = TMR_IDLE;
               count_n = '0;
            end else if (count == TERM) begin
               count_n = '0;
               tok_n   = 1'b1;
            end else begin
               count_n = count + CNT_W'(1);
            end
         end
         default: begin
            state_n = TMR_IDLE;
            count_n = '0;
         end
      endcase
   end

endmodule

// File: rtl/mixer_plant.sv
// Mixing tank plant: saturating level integrator driven by three valves,
// level sensors, sticky overflow/dry-run fault flags and a run timer.
module mixer_plant
   import mixer_pkg::*;
#(
   parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL,
   parameter int unsigned P1_THRESH    = DEF_P1_THRESH,
   parameter int unsigned P2_THRESH    = DEF_P2_THRESH,
   parameter int unsigned TIMER_CYCLES = DEF_TIMER_CYCLES
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               V1,
   input  logic               V2,
   input  logic               V3,
   input  logic               M,
   input  logic               T,
   input  logic               Clr,
   output logic               P1,
   output logic               P2,
   output logic               TOK,
   output logic [LEVEL_W-1:0] Level,
   output logic [FAULT_W-1:0] Fault
);

   localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_LEVEL);

   logic signed [SUM_W-1:0] lvl_s, add_v1, add_v2, sub_v3, sum_c;
   logic [LEVEL_W-1:0]      level_n;
   logic [FAULT_W-1:0]      fault_set, fault_n;
   logic                    ovf_c, dry_c;

   // Net flow in signed arithmetic so a drain below zero is visible before clamping.
   assign lvl_s  = SUM_W'(Level);
   assign add_v1 = V1 ? SUM_W'(RATE_V1) : '0;
   assign add_v2 = V2 ? SUM_W'(RATE_V2) : '0;
   assign sub_v3 = V3 ? SUM_W'(RATE_V3) : '0;
   assign sum_c  = lvl_s + add_v1 + add_v2 - sub_v3;

   assign level_n = sat_level(sum_c, MAX_S);
   assign ovf_c   = !sum_c[SUM_W-1] && (sum_c > MAX_S);
   assign dry_c   = M && (32'(Level) < P2_THRESH);

   // A fault raised on the same edge as Clr survives the clear.
   always_comb begin
      fault_set            = '0;
      fault_set[FAULT_OVF] = ovf_c;
      fault_set[FAULT_DRY] = dry_c;
      fault_n              = fault_set | (Clr ? '0 : Fault);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Level <= '0;
         Fault <= '0;
      end else begin
         Level <= level_n;
         Fault <= fault_n;
      end
   end

   assign P1 = (32'(Level) >= P1_THRESH);
   assign P2 = (32'(Level) >= P2_THRESH);

   mixer_timer #(
      .TIMER_CYCLES(TIMER_CYCLES)
   ) u_timer (
      .Clk  (Clk),
      .Reset(Reset),
      .T    (T),
      .TOK  (TOK)
   );

endmodule

// File: tb/tb_mixer_plant.sv
// Self-checking bench for mixer_plant: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_mixer_plant;

   localparam int MAXL = 200;
   localparam int TH1  = 100;
   localparam int TH2  = 20;
   localparam int TC   = 50;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       V1 = 1'b0, V2 = 1'b0, V3 = 1'b0, M = 1'b0, T = 1'b0, Clr = 1'b0;
   logic       P1, P2, TOK;
   logic [7:0] Level;
   logic [1:0] Fault;

   int errors = 0;
   int n_checks = 0;

   // Behavioural model state
   int m_level = 0;
   int m_fault = 0;
   int m_run   = 0;
   int m_tok   = 0;

   mixer_plant #(
      .MAX_LEVEL(MAXL), .P1_THRESH(TH1), .P2_THRESH(TH2), .TIMER_CYCLES(TC)
   ) dut (
      .Clk(Clk), .Reset(Reset), .V1(V1), .V2(V2), .V3(V3), .M(M), .T(T), .Clr(Clr),
      .P1(P1), .P2(P2), .TOK(TOK), .Level(Level), .Fault(Fault)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: tank arithmetic, sticky flags, and "every TC-th consecutive T-high edge".
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_level = 0; m_fault = 0; m_run = 0; m_tok = 0;
      end else begin
         int nl, set;
         nl  = m_level + 2 * int'(V1) + int'(V2) - 3 * int'(V3);
         set = ((nl > MAXL) ? 1 : 0) | ((M && m_level < TH2) ? 2 : 0);
         m_fault = set | (Clr ? 0 : m_fault);
         m_level = (nl < 0) ? 0 : (nl > MAXL) ? MAXL : nl;
         if (T) begin
            m_run++;
            m_tok = (m_run % TC == 0) ? 1 : 0;
         end else begin
            m_run = 0;
            m_tok = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      chk("level", int'(Level), m_level);
      chk("fault", int'(Fault), m_fault);
      chk("tok", int'(TOK), m_tok);
      chk("p1", int'(P1), (m_level >= TH1) ? 1 : 0);
      chk("p2", int'(P2), (m_level >= TH2) ? 1 : 0);
   end

   task automatic step(input logic v1, input logic v2, input logic v3,
                       input logic m, input logic t, input logic clr);
      V1 = v1; V2 = v2; V3 = v3; M = m; T = t; Clr = clr;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      V1 = 0; V2 = 0; V3 = 0; M = 0; T = 0; Clr = 0;
      Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   initial begin
      int dr[5];
      int toks, wait_n;
      logic v1, v2, v3, m, t, clr;

      dr = '{7, 4, 1, 0, 0};
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      chk("rst_level", int'(Level), 0);
      chk("rst_fault", int'(Fault), 0);
      chk("rst_tok", int'(TOK), 0);
      chk("rst_p1p2", int'({P1, P2}), 0);

      // Fill at +3 per cycle
      for (int e = 1; e <= 34; e++) begin
         step(1, 1, 0, 0, 0, 0);
         if (e == 6) chk("fill_p2_low", int'(P2), 0);
         if (e == 7) begin chk("fill_l7", int'(Level), 21); chk("fill_p2", int'(P2), 1); end
         if (e == 33) chk("fill_p1_low", int'(P1), 0);
         if (e == 34) begin
            chk("fill_l34", int'(Level), 102); chk("fill_p1", int'(P1), 1);
            chk("fill_fault", int'(Fault), 0);
         end
      end

      // Drain with saturation at zero
      do_reset();
      repeat (5) step(1, 0, 0, 0, 0, 0);
      chk("drain_start", int'(Level), 10);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 0, 0, 0);
         chk("drain_level", int'(Level), dr[i]);
         chk("drain_p2", int'(P2), 0);
      end
      chk("drain_fault", int'(Fault), 0);

      // Overflow and Clr priority
      do_reset();
      repeat (66) step(1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("ovf_199", int'(Level), 199);
      step(1, 0, 0, 0, 0, 0);
      chk("ovf_200", int'(Level), 200);
      chk("ovf_set", int'(Fault), 1);
      step(1, 0, 0, 0, 0, 1);
      chk("ovf_clr_lose", int'(Fault), 1);
      step(0, 0, 0, 0, 0, 1);
      chk("ovf_clr", int'(Fault), 0);

      // Dry-run
      do_reset();
      step(0, 0, 0, 1, 0, 0);
      chk("dry_set", int'(Fault), 2);
      step(0, 0, 0, 0, 0, 1);
      chk("dry_clr", int'(Fault), 0);
      repeat (10) step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("dry_l30", int'(Fault), 0);

      // Timer with T held, then an aborted run
      do_reset();
      toks = 0;
      for (int e = 1; e <= 101; e++) begin
         step(0, 0, 0, 0, 1, 0);
         if (TOK) toks++;
         if (e == 49 || e == 50 || e == 51 || e == 100 || e == 101)
            chk("tmr_edge", int'(TOK), (e % 50 == 0) ? 1 : 0);
      end
      chk("tmr_count", toks, 2);
      step(0, 0, 0, 0, 0, 0);
      toks = 0;
      for (int e = 1; e <= 48; e++) begin
         step(0, 0, 0, 0, 1, 0);
         if (TOK) toks++;
      end
      step(0, 0, 0, 0, 0, 0);
      if (TOK) toks++;
      chk("tmr_abort", toks, 0);
      wait_n = 0;
      do begin
         step(0, 0, 0, 0, 1, 0);
         wait_n++;
      end while (!TOK && wait_n < 60);
      chk("tmr_restart", wait_n, 50);

      // Asynchronous reset mid-operation
      do_reset();
      step(0, 0, 0, 1, 1, 0);
      repeat (4) step(0, 0, 0, 0, 1, 0);
      repeat (20) step(1, 1, 0, 0, 1, 0);
      chk("mid_level", int'(Level), 60);
      chk("mid_fault", int'(Fault), 2);
      #2 Reset = 1'b1;
      #1;
      chk("mid_rst_level", int'(Level), 0);
      chk("mid_rst_fault", int'(Fault), 0);
      chk("mid_rst_tok", int'(TOK), 0);
      chk("mid_rst_p2", int'(P2), 0);
      @(posedge Clk);
      #1 Reset = 1'b0;
      wait_n = 0;
      do begin
         step(1, 1, 0, 0, 1, 0);
         wait_n++;
      end while (!TOK && wait_n < 60);
      chk("mid_rst_count", wait_n, 50);

      // Randomized traffic
      do_reset();
      t = 0;
      for (int i = 0; i < 3000; i++) begin
         v1  = 1'($urandom_range(1));
         v2  = 1'($urandom_range(1));
         v3  = 1'($urandom_range(1));
         m   = ($urandom_range(3) == 0);
         clr = ($urandom_range(7) == 0);
         if ($urandom_range(15) == 0) t = ~t;
         step(v1, v2, v3, m, t, clr);
         if ($urandom_range(199) == 0) begin
            #2 Reset = 1'b1;
            #1 chk("rnd_rst_level", int'(Level), 0);
            chk("rnd_rst_tok", int'(TOK), 0);
            chk("rnd_rst_fault", int'(Fault), 0);
            @(posedge Clk);
            #1 Reset = 1'b0;
         end
      end

      @(negedge Clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mixer_plant.md
MIXER_PLANT -- requirements
Module: mixer_plant

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 200, tank capacity in level units.
REQ-002 SHALL have parameter P1_THRESH, default 100, high-level sensor threshold.
REQ-003 SHALL have parameter P2_THRESH, default 20, low-level sensor threshold.
REQ-004 SHALL have parameter TIMER_CYCLES, default 50, timer period in clock cycles.
REQ-005 SHALL have ports: Clk  in  1  clock; rising-edge.
REQ-006 SHALL have ports: Reset  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have ports: V1  in  1  fill valve 1, +2 units/cycle when high.
REQ-008 SHALL have ports: V2  in  1  fill valve 2, +1 unit/cycle when high.
REQ-009 SHALL have ports: V3  in  1  drain valve, -3 units/cycle when high.
REQ-010 SHALL have ports: M  in  1  mixer motor on.
REQ-011 SHALL have ports: T  in  1  timer run request.
REQ-012 SHALL have ports: Clr  in  1  synchronous clear of fault flags.
REQ-013 SHALL have ports: P1  out  1  high-level sensor, 1 when Level >= P1_THRESH.
REQ-014 SHALL have ports: P2  out  1  low-level sensor, 1 when Level >= P2_THRESH.
REQ-015 SHALL have ports: TOK  out  1  timer-expired pulse, one cycle.
REQ-016 SHALL have ports: Level  out  8  current tank level, unsigned.
REQ-017 SHALL have ports: Fault  out  2  sticky flags: [0] overflow, [1] motor dry-run.

Function
REQ-018 SHALL, each rising edge, update Level to Level + 2*V1 + V2 - 3*V3, computed in 10-bit signed arithmetic.
REQ-019 SHALL saturate the Level update at 0 (no wrap) and at MAX_LEVEL.
REQ-020 SHALL handle simultaneous fill and drain by net sum only; V1+V2+V3 gives net 0.
REQ-021 SHALL drive P1/P2 combinationally from the Level register: no extra latency.
REQ-022 SHALL set Fault[0] when the unsaturated update result exceeds MAX_LEVEL.
REQ-023 SHALL set Fault[1] on any edge where M=1 and Level < P2_THRESH.
REQ-024 SHALL clear both Fault bits on an edge with Clr=1; a set condition on the same edge wins over Clr.
REQ-025 SHALL run the timer as two states, IDLE and RUN: IDLE->RUN when T=1; RUN->IDLE when T=0, clearing the count.
REQ-026 SHALL, in RUN, increment an internal count from 0 each edge while T=1.
REQ-027 SHALL, when count = TIMER_CYCLES-1 and T=1, reset count to 0 and register TOK=1 for exactly one cycle, then restart timing if T stays high.
REQ-028 SHALL, with T held high, assert TOK after the TIMER_CYCLES-th edge with T sampled high, and every TIMER_CYCLES cycles thereafter.
REQ-029 SHALL suppress TOK and zero the count if T drops on the same edge the terminal count would be reached.
REQ-030 SHALL keep all outputs stable between edges and free of direct combinational paths from V1..V3, M or T.

Reset
REQ-031 SHALL, on Reset=1 at any time, immediately force Level=0, Fault=2'b00, TOK=0, timer to IDLE with count=0; P1=0 and P2=0 follow.
REQ-032 SHALL resume normal updates on the first rising edge after Reset deasserts.

Structure
REQ-033 SHALL take default thresholds, rates (2/1/3), MAX_LEVEL, TIMER_CYCLES and the Fault bit indices from a shared constants package, mixer_pkg, also used by the controller.
REQ-034 SHALL implement the timer (REQ-025..029) as one sub-module, mixer_timer, parameterised by TIMER_CYCLES; the level/fault logic stays in mixer_plant.

Verification
REQ-035 SHALL cover fill: Level=0, V1=V2=1 -> +3/cycle, P2 rises at Level 21 (edge 7), P1 rises at Level 102 (edge 34), Fault=0.
REQ-036 SHALL cover drain and saturation: Level=10, V3=1 -> 7, 4, 1, 0, 0; P2 stays 0; no fault.
REQ-037 SHALL cover overflow: Level=199, V1=1 -> Level=200, Fault[0]=1; Clr=1 with V1 still 1 -> Fault[0] stays 1; V1=0, Clr=1 -> Fault=0.
REQ-038 SHALL cover the timer: T=1 continuously -> TOK single-cycle pulses after edges 50 and 100; T=0 at edge 49 -> no TOK, count back to 0.
REQ-039 SHALL cover dry-run: Level=0, M=1 -> Fault[1]=1 next edge; Level=30, M=1 after Clr -> Fault[1] stays 0.
REQ-040 SHALL cover reset mid-operation: assert Reset during fill at Level=60 with timer count 25 -> Level, TOK, Fault and count all 0 immediately, without waiting for a clock edge.
